// File: rtl/pll_phase_stepper.sv
// PLL dynamic phase-shift sequencer: accepts signed step commands, issues
// phase_en/updn/cntsel handshakes to the PLL, tracks per-channel positions.
module pll_phase_stepper #(
    parameter int NUM_CH    = 4,
    parameter int STEP_W    = 10,
    parameter int POS_W     = 12,
    parameter int EN_CYCLES = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [4:0]              cmd_ch,
    input  logic [STEP_W-1:0]       cmd_steps,
    input  logic                    pos_clear,
    output logic                    pll_0_phase_en_phase_en,
    output logic                    pll_0_updn_updn,
    output logic [4:0]              pll_0_cntsel_cntsel,
    input  logic                    pll_0_phase_done_phase_done,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err,
    output logic [NUM_CH*POS_W-1:0] pos_flat
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PULSE   = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    localparam int EN_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [EN_W-1:0] EN_LAST  = EN_W'(EN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [4:0]      NUM_CH_L = 5'(NUM_CH);

    logic [2:0]        state_q, state_d;
    logic [EN_W-1:0]   en_cnt_q, en_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [4:0]        cntsel_q, cntsel_d;
    logic              updn_q, updn_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              step_d;
    logic              sync1_q, sync2_q;
    logic [STEP_W-1:0] mag;
    logic [POS_W-1:0]  pos_q [NUM_CH];

    // Two-flop synchronizer for the asynchronous PLL phase_done signal.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pll_0_phase_done_phase_done;
            sync2_q <= sync1_q;
        end
    end

    // Magnitude of the signed step count; the most negative value maps to 2^(STEP_W-1).
    always_comb begin
        mag = cmd_steps;
        if (cmd_steps[STEP_W-1]) begin
            mag = ~cmd_steps + STEP_W'(1);
        end
    end

    // Command sequencing FSM next-state logic.
    always_comb begin
        state_d  = state_q;
        en_cnt_d = en_cnt_q;
        to_cnt_d = to_cnt_q;
        rem_d    = rem_q;
        cntsel_d = cntsel_q;
        updn_d   = updn_q;
        done_d   = 1'b0;
        err_d    = 2'b00;
        step_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ch >= NUM_CH_L) begin
                        err_d = 2'b10;
                    end else if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cntsel_d = cmd_ch;
                        updn_d   = ~cmd_steps[STEP_W-1];
                        rem_d    = mag;
                        en_cnt_d = '0;
                        state_d  = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (en_cnt_q == EN_LAST) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_LO;
                end else begin
                    en_cnt_d = en_cnt_q + EN_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!sync2_q) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_HI;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d    = 2'b01;
                    rem_d    = '0;
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_HI: begin
                if (sync2_q) begin
                    step_d  = 1'b1;
                    rem_d   = rem_q - STEP_W'(1);
                    state_d = S_GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d    = 2'b01;
                    rem_d    = '0;
                    to_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (rem_q != '0) begin
                    en_cnt_d = '0;
                    state_d  = S_PULSE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            en_cnt_q <= '0;
            to_cnt_q <= '0;
            rem_q    <= '0;
            cntsel_q <= '0;
            updn_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            en_cnt_q <= en_cnt_d;
            to_cnt_q <= to_cnt_d;
            rem_q    <= rem_d;
            cntsel_q <= cntsel_d;
            updn_q   <= updn_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Per-channel position accumulators; pos_clear overrides a same-cycle step.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pos_q[i] <= '0;
            end
        end else if (pos_clear) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                pos_q[i] <= '0;
            end
        end else if (step_d) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cntsel_q == 5'(i)) begin
                    pos_q[i] <= updn_q ? (pos_q[i] + POS_W'(1)) : (pos_q[i] - POS_W'(1));
                end
            end
        end
    end

    // Flatten positions onto the output bus.
    always_comb begin
        pos_flat = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pos_flat[i*POS_W +: POS_W] = pos_q[i];
        end
    end

    assign cmd_ready               = (state_q == S_IDLE);
    assign busy                    = (state_q != S_IDLE);
    assign pll_0_phase_en_phase_en = (state_q == S_PULSE);
    assign pll_0_updn_updn         = updn_q;
    assign pll_0_cntsel_cntsel     = cntsel_q;
    assign done                    = done_q;
    assign err                     = err_q;

endmodule
